// File: rtl/lectura_framebuffer_vga.sv
// VGA scan-out of a 320x240 RGB332 frame buffer: timing counters, running RAM address,
// and a 2-stage pipeline that lines up sync with the one-cycle RAM read latency.
module lectura_framebuffer_vga #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DP_RAM_data_out,
  output logic [16:0] DP_RAM_addr_out,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] IMG_W_C  = 10'(IMG_W);
  localparam logic [9:0] IMG_H_C  = 10'(IMG_H);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  hcnt_reg, hcnt_next;
  logic [9:0]  vcnt_reg, vcnt_next;
  logic [16:0] addr_reg, addr_next;
  logic        in_img0, hs0, vs0, frame_end;
  logic        in_img1_reg, hs1_reg, vs1_reg;

  assign in_img0   = (hcnt_reg < IMG_W_C) && (vcnt_reg < IMG_H_C);
  assign hs0       = !((hcnt_reg >= HS_START) && (hcnt_reg < HS_END));
  assign vs0       = !((vcnt_reg >= VS_START) && (vcnt_reg < VS_END));
  assign frame_end = (hcnt_reg == H_LAST) && (vcnt_reg == V_LAST);

  assign DP_RAM_addr_out = addr_reg;

  // The address only advances on image pixels, so it is a plain running count
  // with no row multiply; reload shares the frame-wrap edge.
  always_comb begin
    hcnt_next = hcnt_reg + 10'd1;
    vcnt_next = vcnt_reg;
    addr_next = addr_reg;
    if (hcnt_reg == H_LAST) begin
      hcnt_next = '0;
      vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 10'd1;
    end
    if (frame_end) begin
      addr_next = '0;
    end else if (in_img0) begin
      addr_next = addr_reg + 17'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt_reg    <= '0;
      vcnt_reg    <= '0;
      addr_reg    <= '0;
      in_img1_reg <= 1'b0;
      hs1_reg     <= 1'b1;
      vs1_reg     <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      hcnt_reg    <= hcnt_next;
      vcnt_reg    <= vcnt_next;
      addr_reg    <= addr_next;
      in_img1_reg <= in_img0;
      hs1_reg     <= hs0;
      vs1_reg     <= vs0;
      VGA_HS      <= hs1_reg;
      VGA_VS      <= vs1_reg;
      FRAME_START <= (hcnt_reg == '0) && (vcnt_reg == '0);
      // Replicate MSBs so full-scale RGB332 maps to full-scale RGB444.
      if (in_img1_reg) begin
        VGA_R <= {DP_RAM_data_out[7:5], DP_RAM_data_out[7]};
        VGA_G <= {DP_RAM_data_out[4:2], DP_RAM_data_out[4]};
        VGA_B <= {DP_RAM_data_out[1:0], DP_RAM_data_out[1:0]};
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lectura_framebuffer_vga.sv
// Bench: full-size instance for pixel/line/hsync checks, shrunken-timing instance
// for whole-frame checks (vsync, frame period, address wrap, mid-frame reset).
module tb_lectura_framebuffer_vga;

  // index 0 = full-size 640x480 instance, index 1 = small-geometry instance
  localparam int HT  [2] = '{800, 28};
  localparam int VT  [2] = '{525, 16};
  localparam int IW  [2] = '{320, 8};
  localparam int IH  [2] = '{240, 5};
  localparam int HSS [2] = '{656, 22};
  localparam int HSW [2] = '{96, 3};
  localparam int VSS [2] = '{490, 12};
  localparam int VSW [2] = '{2, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  logic [7:0]  big_q, sm_q;
  logic [16:0] big_addr, sm_addr;
  logic [3:0]  big_r, big_g, big_b, sm_r, sm_g, sm_b;
  logic        big_hs, big_vs, big_fs, sm_hs, sm_vs, sm_fs;
  logic [11:0] big_rgb, sm_rgb;
  assign big_rgb = {big_r, big_g, big_b};
  assign sm_rgb  = {sm_r, sm_g, sm_b};

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  lectura_framebuffer_vga u_big (
    .CLK(clk), .RST(rst), .DP_RAM_data_out(big_q), .DP_RAM_addr_out(big_addr),
    .VGA_R(big_r), .VGA_G(big_g), .VGA_B(big_b),
    .VGA_HS(big_hs), .VGA_VS(big_vs), .FRAME_START(big_fs)
  );

  lectura_framebuffer_vga #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .IMG_W(8), .IMG_H(5)
  ) u_small (
    .CLK(clk), .RST(rst), .DP_RAM_data_out(sm_q), .DP_RAM_addr_out(sm_addr),
    .VGA_R(sm_r), .VGA_G(sm_g), .VGA_B(sm_b),
    .VGA_HS(sm_hs), .VGA_VS(sm_vs), .FRAME_START(sm_fs)
  );

  function automatic logic [7:0] ram_fn(input logic [16:0] a);
    case (a)
      17'd0:     return 8'hE0;
      17'd1:     return 8'h1C;
      17'd2:     return 8'h03;
      17'd3:     return 8'hFF;
      17'd320:   return 8'hFF;
      17'd76800: return 8'hFF;
      default:   return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Synchronous-read RAM models: data valid the cycle after the address.
  always @(posedge clk) begin
    big_q <= ram_fn(big_addr);
    sm_q  <= ram_fn(sm_addr);
  end

  function automatic logic [11:0] expand(input logic [7:0] d);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

  // Closed-form address for scan position p (cycles since frame (0,0)).
  function automatic int exp_addr(input int p, input int s);
    int q = p % (HT[s] * VT[s]);
    int h = q % HT[s];
    int v = q / HT[s];
    if (v < IH[s]) return v * IW[s] + ((h < IW[s]) ? h : IW[s]);
    return IW[s] * IH[s];
  endfunction

  function automatic logic [11:0] exp_rgb(input int p, input int s);
    int q = p % (HT[s] * VT[s]);
    int h = q % HT[s];
    int v = q / HT[s];
    if (h < IW[s] && v < IH[s]) return expand(ram_fn(17'(exp_addr(p, s))));
    return 12'h000;
  endfunction

  function automatic logic exp_hs(input int p, input int s);
    int h = p % HT[s];
    return !(h >= HSS[s] && h < HSS[s] + HSW[s]);
  endfunction

  function automatic logic exp_vs(input int p, input int s);
    int v = (p / HT[s]) % VT[s];
    return !(v >= VSS[s] && v < VSS[s] + VSW[s]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic goto(input int t);
    while (k < t) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
  endtask

  // Cycle-by-cycle comparison of one instance against the closed-form reference.
  task automatic sweep(input int s, input int k_end, input string name);
    int bad = 0;
    int first = -1;
    logic [16:0] a, ea;
    logic [11:0] c, ec;
    logic hs, vs, fs, ehs, evs, efs;
    while (1) begin
      a  = (s == 1) ? sm_addr : big_addr;
      c  = (s == 1) ? sm_rgb  : big_rgb;
      hs = (s == 1) ? sm_hs   : big_hs;
      vs = (s == 1) ? sm_vs   : big_vs;
      fs = (s == 1) ? sm_fs   : big_fs;
      ea = 17'(exp_addr(k, s));
      if (k >= 2) begin
        ec = exp_rgb(k - 2, s); ehs = exp_hs(k - 2, s); evs = exp_vs(k - 2, s);
      end else begin
        ec = 12'h000; ehs = 1'b1; evs = 1'b1;
      end
      efs = (k >= 1) && (((k - 1) % (HT[s] * VT[s])) == 0);
      if (a !== ea || c !== ec || hs !== ehs || vs !== evs || fs !== efs) begin
        bad++;
        if (first < 0) first = k;
      end
      if (k >= k_end) break;
      tick();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL %s: %0d bad cycles (first at k=%0d), required 0", name, bad, first);
    end else begin
      $display("sweep %s: cycles up to k=%0d match", name, k_end);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    repeat (37) tick();
    do_reset(3);
    n_cmp++; if (big_addr !== 17'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", big_addr); end
    n_cmp++; if (big_rgb !== 12'h000) begin n_bad++; $display("FAIL reset_rgb: got %h want 000", big_rgb); end
    n_cmp++; if (big_hs !== 1'b1) begin n_bad++; $display("FAIL reset_hs: got %b want 1", big_hs); end
    n_cmp++; if (big_vs !== 1'b1) begin n_bad++; $display("FAIL reset_vs: got %b want 1", big_vs); end
    n_cmp++; if (big_fs !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %b want 0", big_fs); end
    tick();
    n_cmp++; if (big_fs !== 1'b1) begin n_bad++; $display("FAIL fs_pulse: got %b want 1", big_fs); end
    n_cmp++; if (big_rgb !== 12'h000) begin n_bad++; $display("FAIL refill_rgb: got %h want 000", big_rgb); end
    $display("test_reset done");
  endtask

  task automatic test_first_pixel();
    tick();
    n_cmp++; if (big_fs !== 1'b0) begin n_bad++; $display("FAIL fs_width: got %b want 0", big_fs); end
    n_cmp++; if (big_rgb !== 12'hF00) begin n_bad++; $display("FAIL px0_red: got %h want F00", big_rgb); end
    tick();
    n_cmp++; if (big_rgb !== 12'h0F0) begin n_bad++; $display("FAIL px1_green: got %h want 0F0", big_rgb); end
    tick();
    n_cmp++; if (big_rgb !== 12'h00F) begin n_bad++; $display("FAIL px2_blue: got %h want 00F", big_rgb); end
    tick();
    n_cmp++; if (big_rgb !== 12'hFFF) begin n_bad++; $display("FAIL px3_white: got %h want FFF", big_rgb); end
    $display("test_first_pixel done");
  endtask

  task automatic test_line_boundary();
    goto(319);
    n_cmp++; if (big_addr !== 17'd319) begin n_bad++; $display("FAIL addr_h319: got %0d want 319", big_addr); end
    goto(320);
    n_cmp++; if (big_addr !== 17'd320) begin n_bad++; $display("FAIL addr_h320: got %0d want 320", big_addr); end
    goto(322);
    n_cmp++; if (big_rgb !== 12'h000) begin n_bad++; $display("FAIL blank_col320: got %h want 000", big_rgb); end
    goto(799);
    n_cmp++; if (big_addr !== 17'd320) begin n_bad++; $display("FAIL addr_h799: got %0d want 320", big_addr); end
    goto(800);
    n_cmp++; if (big_addr !== 17'd320) begin n_bad++; $display("FAIL addr_line1: got %0d want 320", big_addr); end
    goto(801);
    n_cmp++; if (big_addr !== 17'd321) begin n_bad++; $display("FAIL addr_line1_h1: got %0d want 321", big_addr); end
    goto(802);
    n_cmp++; if (big_rgb !== 12'hFFF) begin n_bad++; $display("FAIL line1_px0: got %h want FFF", big_rgb); end
    $display("test_line_boundary done");
  endtask

  task automatic test_hsync();
    int low = 0;
    int first_col = -1;
    logic prev = 1'b1;
    do_reset(3);
    while (k <= 801) begin
      if (k >= 2) begin
        if (!big_hs) low++;
        if (!big_hs && prev && first_col < 0) first_col = (k - 2) % 800;
      end
      prev = big_hs;
      tick();
    end
    n_cmp++; if (low !== 96) begin n_bad++; $display("FAIL hs_width: got %0d want 96", low); end
    n_cmp++; if (first_col !== 656) begin n_bad++; $display("FAIL hs_start: got %0d want 656", first_col); end
    sweep(0, 1603, "big_two_lines");
  endtask

  task automatic test_frame();
    int vs_low = 0;
    int hs_pulses = 0;
    int fs1 = -1;
    int fs2 = -1;
    logic prev = 1'b1;
    do_reset(2);
    while (k < 900) begin
      if (k >= 2 && k < 450) begin
        if (!sm_vs) vs_low++;
        if (!sm_hs && prev) hs_pulses++;
      end
      prev = sm_hs;
      if (sm_fs) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      tick();
    end
    n_cmp++; if (vs_low !== 56) begin n_bad++; $display("FAIL vs_width: got %0d want 56", vs_low); end
    n_cmp++; if (hs_pulses !== 16) begin n_bad++; $display("FAIL hs_per_frame: got %0d want 16", hs_pulses); end
    n_cmp++; if (fs1 !== 1) begin n_bad++; $display("FAIL fs_first: got %0d want 1", fs1); end
    n_cmp++; if (fs2 - fs1 !== 448) begin n_bad++; $display("FAIL frame_period: got %0d want 448", fs2 - fs1); end
    $display("test_frame done");
  endtask

  task automatic test_frame_wrap();
    do_reset(1);
    goto(140);
    n_cmp++; if (sm_addr !== 17'd40) begin n_bad++; $display("FAIL wrap_addr_row5: got %0d want 40", sm_addr); end
    goto(171);
    n_cmp++; if (sm_rgb !== 12'h000) begin n_bad++; $display("FAIL wrap_row6_black: got %h want 000", sm_rgb); end
    goto(447);
    n_cmp++; if (sm_addr !== 17'd40) begin n_bad++; $display("FAIL wrap_addr_last: got %0d want 40", sm_addr); end
    goto(448);
    n_cmp++; if (sm_addr !== 17'd0) begin n_bad++; $display("FAIL wrap_addr_zero: got %0d want 0", sm_addr); end
    goto(450);
    n_cmp++; if (sm_rgb !== 12'hF00) begin n_bad++; $display("FAIL frame2_px0: got %h want F00", sm_rgb); end
    goto(451);
    n_cmp++; if (sm_rgb !== 12'h0F0) begin n_bad++; $display("FAIL frame2_px1: got %h want 0F0", sm_rgb); end
    sweep(1, 906, "small_two_frames");
  endtask

  task automatic test_mid_reset();
    goto(995);
    n_cmp++; if (sm_addr !== 17'd32) begin n_bad++; $display("FAIL pre_reset_addr: got %0d want 32", sm_addr); end
    do_reset(1);
    n_cmp++; if (sm_addr !== 17'd0) begin n_bad++; $display("FAIL mid_reset_addr: got %0d want 0", sm_addr); end
    sweep(1, 460, "small_after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_line_boundary();
    test_hsync();
    test_frame();
    test_frame_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lectura_framebuffer_vga.md
# lectura_framebuffer_vga

Downstream consumer of the camera capture stage: it generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock and reads the dual-port frame RAM (read port) holding a 320x240 RGB332 image. The image is shown 1:1 in the top-left 320x240 of the screen, with black elsewhere. The block expands each byte to RGB444 for the board DAC and aligns sync and colour through a 2-stage read pipeline.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch (V_TOTAL = 525)
- IMG_W / IMG_H, 320 / 240, stored image size; IMG_W*IMG_H must be ≤ 2^17
- CLK  in  1  25 MHz pixel clock; single clock domain
- RST  in  1  synchronous, active-high reset
- DP_RAM_data_out  in  8  RAM read data, RGB332 {R[7:5],G[4:2],B[1:0]}; valid the cycle after the address
- DP_RAM_addr_out  out  17  RAM read address
- VGA_R / VGA_G / VGA_B  out  4 each  colour
- VGA_HS / VGA_VS  out  1 each  syncs, active low
- FRAME_START  out  1  one-cycle pulse when counters are at (0,0)

## Operation
- Stage 0 registers: hcnt (0..H_TOTAL-1) and vcnt (0..V_TOTAL-1).
  - hcnt increments every cycle and wraps to 0.
  - vcnt increments when hcnt wraps, and wraps to 0 after V_TOTAL-1.
- Address counter addr (17 bit) drives DP_RAM_addr_out directly. It is a running counter, not a multiplier.
  - Increments by 1 on each cycle where hcnt<IMG_W and vcnt<IMG_H.
  - Holds in all other cycles.
  - Loads 0 when hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1.
  - After the last image pixel it reads IMG_W*IMG_H (76800). That read is out of range, and its data is masked.
- in_img0 = (hcnt<IMG_W)&&(vcnt<IMG_H).
- hs0 = low when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC (656..751).
- vs0 = low when V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Stage 1: delay in_img, hs and vs by one register, covering the RAM read latency.
- Stage 2 output registers, updated from stage 1 and DP_RAM_data_out:
  - R = {d[7:5],d[7]}
  - G = {d[4:2],d[4]}
  - B = {d[1:0],d[1:0]}
  - R/G/B are all 0 when in_img1=0.
  - VGA_HS/VGA_VS take hs1/vs1.
- FRAME_START is registered, and is high in the cycle where hcnt=0 and vcnt=0 are visible.

## Timing
- Reset:
  - hcnt=vcnt=addr=0 and pipeline flags in_img=0.
  - hs/vs pipeline = 1.
  - VGA_R/G/B=0, VGA_HS=VGA_VS=1, FRAME_START=0, DP_RAM_addr_out=0.
- RST asserted mid-frame:
  - All state returns to the reset values at the next edge.
  - Colour stays 0 for 2 cycles after release, while the pipeline refills.
- Latency: colour and sync for counter position (h,v) appear on the outputs exactly 2 cycles after hcnt=h, vcnt=v.
- Sync pulse widths are exact: HS is low for 96 cycles per line, and VS is low for 2 full lines (1600 cycles) per frame.
- Frame period is 420000 cycles.
- The counter wrap and the addr reload to 0 happen on the same edge, so the first pixel of every frame reads address 0.
- The address never changes during cycles outside the image, including the full horizontal blanking interval.

## Test plan
- Reset: hold RST for 3 cycles mid-line -> next cycle addr=0, RGB=0, HS=VS=1, then FRAME_START pulses 1 cycle after release.
- First pixel: RAM model returns 0xE0 at addr 0, 0x1C at addr 1, 0x03 at addr 2.
  - Outputs 2 cycles after hcnt=0/1/2: RGB=F00, 0F0, 00F.
  - 0xFF gives FFF.
- Line boundary:
  - Line 0 shows addr 0..319 on hcnt 0..319.
  - addr holds 320 for hcnt 320..799.
  - Line 1 hcnt=0 reads 320.
  - RGB is 0 for output columns ≥320 even if the RAM returns 0xFF.
- Sync: over one frame count HS low = 96 cycles starting at output column 656, and VS low = lines 490–491.
  - Per-frame counts: 525 HS pulses and 420000 total cycles.
- Frame wrap:
  - After line 239, addr=76800 holds through line 524.
  - Returns to 0 at the frame boundary.
  - Second frame pixel (0,0) again shows the addr-0 colour.
  - Rows ≥240 are black.
- Mid-operation reset: assert RST at hcnt=500, vcnt=100 for 1 cycle -> counters restart at (0,0) and addr=0, and outputs match a freshly reset reference for the next full frame.
